// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        EXC   = 3'd4,
        ERR   = 3'd5
    } state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/muldiv_sequencer.sv
// Sequences one MULT/DIV request through the shared units and the HI/LO registers.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic req_valid,
    input  logic req_op,
    output logic req_ready,
    output logic mult_start,
    output logic div_start,
    input  logic mult_fim,
    input  logic div_fim,
    input  logic DividedByZero,
    output logic HISelector,
    output logic LOSelector,
    output logic RegHIWrite,
    output logic RegLOWrite,
    output logic done,
    output logic div_zero_exc,
    output logic timeout_err,
    output logic busy,
    input  logic hilo_read_req,
    output logic hilo_stall
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q;
    state_t           state_d;
    logic             op_q;
    logic             op_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             fim_sel;

    // Only the selected unit's completion flag is considered
    assign fim_sel = (op_q == OP_DIV) ? div_fim : mult_fim;

    // Next-state, op latch and wait-counter logic
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if ((op_q == OP_DIV) && DividedByZero) begin
                    state_d = EXC;
                end else if (fim_sel) begin
                    state_d = WRITE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ERR;
                end
            end
            WRITE:   state_d = IDLE;
            EXC:     state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, op and counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_MULT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore outputs registered from the next state so they line up with the state register
    always_ff @(posedge clock) begin
        if (reset) begin
            req_ready    <= 1'b1;
            busy         <= 1'b0;
            mult_start   <= 1'b0;
            div_start    <= 1'b0;
            HISelector   <= OP_MULT;
            LOSelector   <= OP_MULT;
            RegHIWrite   <= 1'b0;
            RegLOWrite   <= 1'b0;
            done         <= 1'b0;
            div_zero_exc <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            req_ready    <= (state_d == IDLE);
            busy         <= (state_d != IDLE);
            mult_start   <= (state_d == START) && (op_d == OP_MULT);
            div_start    <= (state_d == START) && (op_d == OP_DIV);
            HISelector   <= op_d;
            LOSelector   <= op_d;
            RegHIWrite   <= (state_d == WRITE);
            RegLOWrite   <= (state_d == WRITE);
            done         <= (state_d == WRITE);
            div_zero_exc <= (state_d == EXC);
            timeout_err  <= (state_d == ERR);
        end
    end

    // MFHI/MFLO interlock while an operation is in flight
    assign hilo_stall = hilo_read_req && busy;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed scoreboard bench for muldiv_sequencer.
module tb_muldiv_sequencer;

    localparam int unsigned TO = 8;

    logic clock = 1'b0;
    logic reset;
    logic req_valid, req_op, req_ready;
    logic mult_start, div_start, mult_fim, div_fim, DividedByZero;
    logic HISelector, LOSelector, RegHIWrite, RegLOWrite;
    logic done, div_zero_exc, timeout_err, busy;
    logic hilo_read_req, hilo_stall;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int   evt;   // 1 = done, 2 = divide-by-zero, 3 = timeout
        logic sel;
        int   k;     // cycle of the terminal pulse, counted from acceptance
    } exp_t;

    exp_t exp_q[$];

    muldiv_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_op        (req_op),
        .req_ready     (req_ready),
        .mult_start    (mult_start),
        .div_start     (div_start),
        .mult_fim      (mult_fim),
        .div_fim       (div_fim),
        .DividedByZero (DividedByZero),
        .HISelector    (HISelector),
        .LOSelector    (LOSelector),
        .RegHIWrite    (RegHIWrite),
        .RegLOWrite    (RegLOWrite),
        .done          (done),
        .div_zero_exc  (div_zero_exc),
        .timeout_err   (timeout_err),
        .busy          (busy),
        .hilo_read_req (hilo_read_req),
        .hilo_stall    (hilo_stall)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, req_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_pulses"}, {mult_start, div_start, done, div_zero_exc, timeout_err}, 0);
        chk({tag, "_wr"}, {RegHIWrite, RegLOWrite}, 0);
        chk({tag, "_stall"}, hilo_stall, 0);
    endtask

    // Runs one request; fim_at/dz_at are 1-based WAIT cycle numbers (0 = never),
    // wrong holds the unselected unit's flags (and DividedByZero for MULT) high.
    task automatic run_op(input logic op, input int fim_at, input int dz_at,
                          input logic wrong, input int exp_evt, input int exp_k);
        int   k;
        int   w;
        int   obs_evt;
        logic seen;
        exp_q.push_back('{evt: exp_evt, sel: op, k: exp_k});
        chk("ready_before", req_ready, 1);
        req_valid = 1'b1;
        req_op    = op;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 100) begin
            @(negedge clock);
            k++;
            w = k - 1;
            req_valid = 1'b0;
            chk("busy", busy, 1);
            chk("ready_low", req_ready, 0);
            chk("stall", hilo_stall, hilo_read_req);
            chk("mult_start", mult_start, (k == 1) && !op);
            chk("div_start", div_start, (k == 1) && op);
            chk("hi_wr", RegHIWrite, done);
            chk("lo_wr", RegLOWrite, done);
            if (done || div_zero_exc || timeout_err) begin
                seen = 1'b1;
                obs_evt = done ? 1 : (div_zero_exc ? 2 : 3);
                chk("one_pulse", 32'(done) + 32'(div_zero_exc) + 32'(timeout_err), 1);
                chk("sb_nonempty", exp_q.size(), 1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_evt", obs_evt, e.evt);
                    chk("sb_cycle", k, e.k);
                    chk("sb_hisel", HISelector, e.sel);
                    chk("sb_losel", LOSelector, e.sel);
                end
                mult_fim      = 1'b0;
                div_fim       = 1'b0;
                DividedByZero = 1'b0;
            end else begin
                mult_fim      = op ? wrong : (fim_at != 0 && w == fim_at);
                div_fim       = op ? (fim_at != 0 && w == fim_at) : wrong;
                DividedByZero = (dz_at != 0 && w == dz_at) || (!op && wrong);
            end
        end
        chk("terminal_seen", seen, 1);
        @(negedge clock);
        chk_idle("after_op");
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0;
        req_op = 1'b0;
        mult_fim = 1'b0;
        div_fim = 1'b0;
        DividedByZero = 1'b0;
        hilo_read_req = 1'b0;
        repeat (2) @(negedge clock);
        chk_idle("reset");
        chk("reset_sel", {HISelector, LOSelector}, 0);
        reset = 1'b0;
        @(negedge clock);

        // Idle read is never stalled
        hilo_read_req = 1'b1;
        #1;
        chk("idle_read_stall", hilo_stall, 0);

        // MULT, fim in 5th WAIT cycle, read held throughout: ready back at k = 8
        run_op(1'b0, 5, 0, 1'b0, 1, 7);
        hilo_read_req = 1'b0;

        // DIV, fim in 3rd WAIT cycle
        run_op(1'b1, 3, 0, 1'b0, 1, 5);

        // DIV, DividedByZero together with div_fim in WAIT cycle 2
        run_op(1'b1, 2, 2, 1'b0, 2, 4);

        // Timeout: no fim for TO WAIT cycles
        run_op(1'b0, 0, 0, 1'b0, 3, TO + 2);

        // fim in the last WAIT cycle beats timeout
        run_op(1'b1, TO, 0, 1'b0, 1, TO + 2);

        // MULT ignores div_fim and DividedByZero
        run_op(1'b0, 4, 0, 1'b1, 1, 6);

        // DIV ignores mult_fim and times out
        run_op(1'b1, 0, 0, 1'b1, 3, TO + 2);

        // Reset in the middle of WAIT aborts with no pulse
        req_valid = 1'b1;
        req_op    = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        repeat (2) @(negedge clock);
        chk("pre_reset_busy", busy, 1);
        reset = 1'b1;
        @(negedge clock);
        chk_idle("mid_reset");
        chk("mid_reset_sel", HISelector, 0);
        reset   = 1'b0;
        div_fim = 1'b1;
        @(negedge clock);
        chk_idle("post_reset");
        div_fim = 1'b0;
        @(negedge clock);
        chk_idle("post_reset2");

        chk("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
